cube_cell_editor: RTL

- Interactive seed-board editor for the 8x8x8 LED cube. It is the writer for the 512-bit cell vector that conway_sim reads.
- Debounced buttons move a cursor and toggle or clear cells. A commit offers the edited board to the simulator over a valid/ack load handshake.
- Also drives a preview vector that cube_output can display while the user edits.

---
 rtl/cube_cell_editor_if.sv | 29 ++
 rtl/cube_cell_editor.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/cube_cell_editor_if.sv
// Button, layer and load-handshake bundle between the cube seed editor and its surroundings.
// master = board/driver side, slave = cube_cell_editor.
interface cube_cell_editor_if;
    logic         btn_l;
    logic         btn_r;
    logic         btn_u;
    logic         btn_d;
    logic         btn_t;
    logic         btn_clr;
    logic         btn_commit;
    logic [2:0]   layer;
    logic         load_ack;
    logic [511:0] edit_cells;
    logic [511:0] preview_cells;
    logic [2:0]   cursor_x;
    logic [2:0]   cursor_y;
    logic [2:0]   cursor_z;
    logic         load_valid;

    modport master (
        output btn_l, btn_r, btn_u, btn_d, btn_t, btn_clr, btn_commit, layer, load_ack,
        input  edit_cells, preview_cells, cursor_x, cursor_y, cursor_z, load_valid
    );

    modport slave (
        input  btn_l, btn_r, btn_u, btn_d, btn_t, btn_clr, btn_commit, layer, load_ack,
        output edit_cells, preview_cells, cursor_x, cursor_y, cursor_z, load_valid
    );
endinterface

// File: rtl/cube_cell_editor.sv
// Seed-board editor for the 8x8x8 cube: debounced cursor/toggle/clear buttons, valid/ack board offer.
// Optional cursor blink on the preview vector when CUBE_EDITOR_BLINK_EN is defined.
module cube_cell_editor #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic             i_clk,
    input  logic             i_rst,
    cube_cell_editor_if.slave io_bus
);
    localparam int NB = 7;
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int B_L = 0, B_R = 1, B_U = 2, B_D = 3, B_T = 4, B_CLR = 5, B_COM = 6;

    if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_chk
        $error("cube_cell_editor: DEBOUNCE_CYCLES and BLINK_CYCLES must be >= 1");
    end

    typedef enum logic {S_EDIT, S_OFFER} state_t;

    logic [NB-1:0]  w_btn_raw;
    logic [NB-1:0]  r_btn_s1, r_btn_s2, r_btn_acc, r_btn_evt;
    logic [CW-1:0]  r_cnt [NB];
    logic [2:0]     r_layer_s1, r_layer_s2;

    state_t         r_state, w_state_nxt;
    logic [511:0]   r_edit, w_edit_nxt;
    logic [511:0]   r_preview, w_preview_nxt;
    logic [2:0]     r_x, r_y, w_x_nxt, w_y_nxt;
    logic [8:0]     w_idx;

    assign w_btn_raw = {io_bus.btn_commit, io_bus.btn_clr, io_bus.btn_t, io_bus.btn_d,
                        io_bus.btn_u, io_bus.btn_r, io_bus.btn_l};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn_s1   <= '0;
            r_btn_s2   <= '0;
            r_layer_s1 <= '0;
            r_layer_s2 <= '0;
        end else begin
            r_btn_s1   <= w_btn_raw;
            r_btn_s2   <= r_btn_s1;
            r_layer_s1 <= io_bus.layer;
            r_layer_s2 <= r_layer_s1;
        end
    end

    // Counter runs only while the synchronized level disagrees with the accepted one,
    // so any bounce back to the accepted level restarts the stability window.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_btn_acc <= '0;
            r_btn_evt <= '0;
            for (int i = 0; i < NB; i++) r_cnt[i] <= '0;
        end else begin
            r_btn_evt <= '0;
            for (int i = 0; i < NB; i++) begin
                if (r_btn_s2[i] == r_btn_acc[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_cnt[i]     <= '0;
                    r_btn_acc[i] <= r_btn_s2[i];
                    r_btn_evt[i] <= r_btn_s2[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_idx = {r_layer_s2, r_y, r_x};

    always_comb begin
        w_state_nxt = r_state;
        w_edit_nxt  = r_edit;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        case (r_state)
            S_EDIT: begin
                if (r_btn_evt[B_CLR]) begin
                    w_edit_nxt = '0;
                end else begin
                    if (r_btn_evt[B_T])
                        w_edit_nxt[w_idx] = ~r_edit[w_idx];
                    if (r_btn_evt[B_R] && !r_btn_evt[B_L])
                        w_x_nxt = r_x + 3'd1;
                    else if (r_btn_evt[B_L] && !r_btn_evt[B_R])
                        w_x_nxt = r_x - 3'd1;
                    if (r_btn_evt[B_U] && !r_btn_evt[B_D])
                        w_y_nxt = r_y + 3'd1;
                    else if (r_btn_evt[B_D] && !r_btn_evt[B_U])
                        w_y_nxt = r_y - 3'd1;
                end
                if (r_btn_evt[B_COM])
                    w_state_nxt = S_OFFER;
            end
            S_OFFER: begin
                if (io_bus.load_ack)
                    w_state_nxt = S_EDIT;
            end
            default: w_state_nxt = S_EDIT;
        endcase
    end

`ifdef CUBE_EDITOR_BLINK_EN
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink;
    logic [511:0]  w_cursor_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else if (r_blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            r_blink_cnt <= '0;
            r_blink     <= ~r_blink;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Overlay uses the cursor as it will be after this edge so it tracks CursorX/Y/Z exactly.
    assign w_cursor_mask = (r_blink && (w_state_nxt == S_EDIT)) ?
                           (512'd1 << {r_layer_s1, w_y_nxt, w_x_nxt}) : '0;
    assign w_preview_nxt = w_edit_nxt ^ w_cursor_mask;
`else
    assign w_preview_nxt = w_edit_nxt;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_EDIT;
            r_edit    <= '0;
            r_preview <= '0;
            r_x       <= '0;
            r_y       <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_edit    <= w_edit_nxt;
            r_preview <= w_preview_nxt;
            r_x       <= w_x_nxt;
            r_y       <= w_y_nxt;
        end
    end

    assign io_bus.edit_cells    = r_edit;
    assign io_bus.preview_cells = r_preview;
    assign io_bus.cursor_x      = r_x;
    assign io_bus.cursor_y      = r_y;
    assign io_bus.cursor_z      = r_layer_s2;
    assign io_bus.load_valid    = (r_state == S_OFFER);
endmodule
